// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among N_REQ requesters. A tag
// pipeline follows each operation and steers its product to the requester's response register.
module mult_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 4,
    parameter int LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [N_REQ-1:0]           resp_valid,
    input  logic [N_REQ-1:0]           resp_ready,
    output logic [N_REQ*2*WIDTH-1:0]   resp_y,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [2*WIDTH-1:0]         mul_y,
    output logic                       idle
);
    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]    ptr;
    logic [LAT-1:0]   tag_valid;
    logic [IW-1:0]    tag_idx [LAT];
    logic [N_REQ-1:0] in_flight;
    logic [N_REQ-1:0] busy;
    logic             grant;
    logic [IW-1:0]    grant_idx;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        in_flight = '0;
        for (int s = 0; s < LAT; s++) begin
            if (tag_valid[s]) in_flight[tag_idx[s]] = 1'b1;
        end
    end

    assign busy = in_flight | resp_valid;
    assign idle = ~(|tag_valid) && ~(|resp_valid);

    // Walk from the farthest candidate back to ptr so the nearest eligible one wins.
    always_comb begin
        int            cand;
        logic [IW-1:0] cidx;
        grant     = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cidx      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            cidx = IW'(cand);
            if (req_valid[cidx] && !busy[cidx]) begin
                grant     = 1'b1;
                grant_idx = cidx;
            end
        end
        if (rst) grant = 1'b0;
    end

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
            mul_a = req_a[grant_idx*WIDTH +: WIDTH];
            mul_b = req_b[grant_idx*WIDTH +: WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            tag_valid  <= '0;
            resp_valid <= '0;
            resp_y     <= '0;
        end else begin
            if (grant) ptr <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            tag_valid[0] <= grant;
            for (int s = 1; s < LAT; s++) tag_valid[s] <= tag_valid[s-1];
            for (int i = 0; i < N_REQ; i++) begin
                if (resp_valid[i] && resp_ready[i]) resp_valid[i] <= 1'b0;
            end
            // busy blocks regrant, so a capture never collides with a release of the same index.
            if (tag_valid[LAT-1]) begin
                resp_valid[tag_idx[LAT-1]] <= 1'b1;
                resp_y[tag_idx[LAT-1]*2*WIDTH +: 2*WIDTH] <= mul_y;
            end
        end
    end

    // NOTE: the index payload is not reset; tag_valid alone qualifies it.
    always_ff @(posedge clk) begin
        tag_idx[0] <= grant_idx;
        for (int s = 1; s < LAT; s++) tag_idx[s] <= tag_idx[s-1];
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized scoreboard bench for mult_share_arbiter with a stand-in two-stage multiplier.
module tb_mult_share_arbiter;
    localparam int W   = 16;
    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int W2  = 2 * W;

    typedef struct {
        int            idx;
        logic [W2-1:0] prod;
        int            due;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a = '0;
    logic [N*W-1:0]  req_b = '0;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready = '0;
    logic [N*W2-1:0] resp_y;
    logic [W-1:0]    mul_a, mul_b;
    logic [W2-1:0]   mul_y;
    logic            idle;

    logic [W-1:0]    m_a_r, m_b_r;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mptr;
    bit   mbusy[N];
    int   mdue[N];
    int   grant_cnt[N];
    logic [N-1:0] last_ready;

    mult_share_arbiter #(.WIDTH(W), .N_REQ(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in multiplier: input register then output register, no reset.
    always @(posedge clk) begin
        m_a_r <= mul_a;
        m_b_r <= mul_b;
        mul_y <= W2'(m_a_r) * W2'(m_b_r);
    end

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mptr = 0;
        for (int i = 0; i < N; i++) begin
            mbusy[i] = 1'b0;
            mdue[i]  = 0;
        end
        sb_q.delete();
    endtask

    task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One cycle: sample at negedge, check the arbiter against the model, then advance.
    task automatic step();
        int           g;
        int           j;
        logic [N-1:0] exp_ready;
        bit           any_busy;
        @(negedge clk);
        last_ready = req_ready;
        for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) grant_cnt[i]++;
        if (rst) begin
            model_reset();
            check("rst_req_ready", req_ready, 0);
            check("rst_mul_a", mul_a, 0);
            check("rst_mul_b", mul_b, 0);
        end else begin
            any_busy = 1'b0;
            for (int i = 0; i < N; i++) if (mbusy[i]) any_busy = 1'b1;
            check("idle", idle, !any_busy);
            g = -1;
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (g < 0 && req_valid[j] && !mbusy[j]) g = j;
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            if (g >= 0) begin
                check("mul_a", mul_a, req_a[g*W +: W]);
                check("mul_b", mul_b, req_b[g*W +: W]);
            end else begin
                check("mul_a_idle", mul_a, 0);
                check("mul_b_idle", mul_b, 0);
            end
            for (int i = 0; i < N; i++) begin
                if (mbusy[i] && cyc >= mdue[i] && resp_ready[i]) mbusy[i] = 1'b0;
            end
            if (g >= 0) begin
                mbusy[g] = 1'b1;
                mdue[g]  = cyc + LAT + 1;
                mptr     = (g + 1) % N;
                sb_q.push_back('{idx: g,
                                 prod: W2'(req_a[g*W +: W]) * W2'(req_b[g*W +: W]),
                                 due: cyc + LAT + 1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: valid timing, held value, and pop on handshake.
    always @(negedge clk) begin
        int  found;
        bit  exp_rv;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                found = -1;
                for (int k = 0; k < sb_q.size(); k++) begin
                    if (found < 0 && sb_q[k].idx == i) found = k;
                end
                exp_rv = (found >= 0) && (sb_q[found].due <= cyc);
                check($sformatf("resp_valid[%0d]", i), resp_valid[i], exp_rv);
                if (resp_valid[i] && exp_rv) begin
                    check($sformatf("resp_y[%0d]", i), resp_y[i*W2 +: W2], sb_q[found].prod);
                    if (resp_ready[i]) sb_q.delete(found);
                end
            end
        end
    end

    initial begin
        int bp_before;
        model_reset();
        for (int i = 0; i < N; i++) grant_cnt[i] = 0;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_resp_y", resp_y, 0);
        check("rst_resp_valid", resp_valid, 0);

        // Single op, held until accepted.
        set_op(0, 16'h00FF, 16'h0101);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (7) step();
        resp_ready = 4'hF;
        repeat (2) step();

        // Round-robin with all requesters continuously valid.
        for (int i = 0; i < N; i++) set_op(i, W'(i + 1), 16'hFFFF);
        req_valid = 4'hF;
        repeat (16) step();
        req_valid = '0;
        repeat (5) step();

        // Back-pressure on requester 1.
        bp_before  = grant_cnt[1];
        resp_ready = 4'b1101;
        req_valid  = 4'hF;
        repeat (20) begin
            for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
            step();
        end
        check("bp_one_grant", grant_cnt[1] - bp_before, 1);
        req_valid  = '0;
        resp_ready = 4'hF;
        repeat (5) step();

        // Extremes.
        set_op(0, 16'hFFFF, 16'hFFFF);
        set_op(2, 16'h0000, 16'h1234);
        req_valid = 4'b0101;
        step();
        step();
        req_valid = '0;
        repeat (5) step();

        // Reset one cycle after a grant; ptr restarts at 0.
        set_op(2, 16'h1111, 16'h2222);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) step();
        req_valid = 4'hF;
        step();
        check("ptr_restart", last_ready, 4'b0001);
        req_valid = '0;
        repeat (5) step();

        // Pointer fairness: bring ptr to 2, then offer requesters 1 and 3.
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        repeat (5) step();
        req_valid = 4'b1010;
        step();
        check("fair_first", last_ready, 4'b1000);
        step();
        check("fair_second", last_ready, 4'b0010);
        req_valid = '0;
        repeat (5) step();

        // Random traffic.
        repeat (1500) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                set_op(i, ($urandom_range(7) == 0) ? 16'hFFFF : W'($urandom),
                          ($urandom_range(7) == 0) ? 16'h0000 : W'($urandom));
                resp_ready[i] = ($urandom_range(3) != 0);
            end
            step();
        end

        req_valid  = '0;
        resp_ready = 4'hF;
        repeat (8) step();
        check("drain_empty", sb_q.size(), 0);
        check("final_idle", idle, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Shares one pipelined array multiplier between `N_REQ` independent requesters, using round-robin arbitration and a valid/ready handshake on both the request and response sides. It presents each granted operand pair to the multiplier and carries a requester tag alongside the fixed-latency multiplier pipeline. When the product emerges, it is steered into that requester's response register, which holds it until the requester accepts it. The block sits directly in front of the multiplier instance; its `mul_*` ports connect straight to the multiplier's `a`, `b` and `y`.

## Interface
- `WIDTH`, 16: operand width; products are 2*WIDTH bits.
- `N_REQ`, 4: number of requesters, 2..8.
- `LAT`, 2: multiplier latency in cycles, from operands presented to `y` valid. This is 1 for the input register plus 1 for the output register.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester grant; request accepted when valid&&ready.
- `req_a`  in  N_REQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH  operand b, same packing.
- `resp_valid`  out  N_REQ  per-requester product valid.
- `resp_ready`  in  N_REQ  per-requester product accept.
- `resp_y`  out  N_REQ*2*WIDTH  product for requester i at [i*2*WIDTH +: 2*WIDTH].
- `mul_a`, `mul_b`  out  WIDTH  operands to the multiplier.
- `mul_y`  in  2*WIDTH  multiplier product.
- `idle`  out  1  high when nothing is in flight and no `resp_valid` bit is set.

## Operation
- **Per-requester busy flag:** `busy[i]` = (op for i in flight) | `resp_valid[i]`.
- **Eligibility:** requester i is eligible when `req_valid[i] && !busy[i]`. Each requester has at most one outstanding operation.
- **Round-robin grant:** a priority pointer `ptr` (reset 0) selects the first eligible index searching `ptr`, `ptr`+1, … mod `N_REQ`.
  - At most one `req_ready` bit is high per cycle. It is combinational from `req_valid`, `busy` and `ptr`.
  - After a grant to index g, `ptr` <= (g+1) mod `N_REQ`. With no grant, `ptr` holds.
- **Operand drive:** `mul_a`/`mul_b` are combinationally muxed from the granted requester. They are driven to 0 when there is no grant.
- **Tag pipeline:** a `LAT`-deep shift register of {valid, index}.
  - Stage 0 loads {grant, g} each cycle.
  - When the last stage is valid, `mul_y` is captured into `resp_y[index]` and `resp_valid[index]` is set.
- **Response release:** `resp_valid[i]` clears on `resp_valid[i] && resp_ready[i]`. `resp_y[i]` keeps its last value.
- **Capture and release in the same cycle:** this cannot occur for one index, because `busy` blocks the regrant.
- **Re-issue timing:** a requester whose response is accepted in cycle T may be granted again no earlier than cycle T+1. Its `busy` flag is registered state and is still set in cycle T.
- **Arithmetic:** the product is the unsigned full 2*WIDTH product. There is no truncation and no saturation.
- **Multiplier has no reset:** its output is ignored except when a valid tag reaches the last stage.

## Timing
- **Reset values:**
  - `req_ready`=0 while `rst` is high.
  - `resp_valid`=0, `resp_y`=0, `ptr`=0, all tag valids 0.
  - `idle`=1 from the cycle after reset.
  - `mul_a`=`mul_b`=0 while `rst` is high.
- **Latency:** handshake in cycle T → `resp_valid` high from cycle T+`LAT`+1 (T+3 at default).
- **Throughput:**
  - Aggregate: one accepted request per cycle when at least one requester is eligible.
  - Per requester: at best one per `LAT`+2 cycles, given an immediate `resp_ready`.
- **Stalled responses:** `resp_ready` low stalls only that requester. Other requesters continue back-to-back.
- **Reset mid-operation:** all in-flight ops and held responses are discarded and no response is produced for them. Requesters must reissue.
- `idle` is registered-state derived (combinational OR of tag valids and `resp_valid`), with no extra delay.

## Test plan
- **Single op:** req 0 issues a=0x00FF, b=0x0101 in cycle 5 → `req_ready[0]`=1 in cycle 5, `resp_valid[0]` from cycle 8 with `resp_y[0]`=0x0000FFFF, held until `resp_ready[0]`.
- **Round-robin:** all 4 requesters hold valid continuously, each with a=i+1, b=0xFFFF, and `resp_ready` tied high → grants go 0,1,2,3,0,… one per cycle, with each requester regranted only after its response handshake. Products are (i+1)*0xFFFF to the correct index.
- **Back-pressure:** `resp_ready[1]` held low for 20 cycles with req 1 valid → exactly one grant to req 1, `resp_valid[1]` stays high with a stable value, and requesters 0/2/3 continue unaffected.
- **Extremes:** a=b=0xFFFF → 0xFFFE0001; a=0, b=0x1234 → 0.
- **Reset mid-flight:** `rst` asserted one cycle after a grant → no `resp_valid` ever appears for that op, `idle`=1 after reset, and `ptr` restarts at 0.
- **Pointer fairness:** only reqs 1 and 3 valid, `ptr`=2 → req 3 is granted first, then req 1.
